// File: rtl/pkg_bcd.sv
// Shared types and constants for the 4-digit BCD to binary converter.
package pkg_bcd;

  localparam int unsigned NUM_DIGITOS = 4;
  localparam int unsigned BASE        = 10;
  localparam int unsigned ANCHO       = 16;
  localparam logic [3:0]  MAX_DIGITO  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACUM = 2'd1,
    FIN  = 2'd2
  } estado_t;

endpackage

// File: rtl/module_mac10.sv
// One Horner step: acc*10 + digit, using shifts instead of a multiplier.
module module_mac10
  import pkg_bcd::*;
(
  input  logic [ANCHO-1:0] i_acc,
  input  logic [3:0]       i_digito,
  output logic [ANCHO-1:0] o_resultado
);

  logic [ANCHO-1:0] w_x8;
  logic [ANCHO-1:0] w_x2;

  assign w_x8        = i_acc << 3;
  assign w_x2        = i_acc << 1;
  assign o_resultado = w_x8 + w_x2 + {12'd0, i_digito};

endmodule

// File: rtl/module_bcd_binario.sv
// Converts a latched 4-digit BCD number to binary, one digit per clock
// (most significant first); flags any digit above 9 and forces a zero result.
module module_bcd_binario #(
  parameter int unsigned NUM_DIGITOS = pkg_bcd::NUM_DIGITOS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inicio,
  input  logic [3:0]  millares_input,
  input  logic [3:0]  centenas_input,
  input  logic [3:0]  decenas_input,
  input  logic [3:0]  unidades_input,
  output logic [15:0] numero_output,
  output logic        listo,
  output logic        error
);

  localparam int unsigned IDX_W  = 2;
  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(NUM_DIGITOS - 1);

  pkg_bcd::estado_t r_estado;
  pkg_bcd::estado_t w_estado_sig;

  logic [15:0]      r_acc;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_digitos [NUM_DIGITOS];
  logic             r_err_acum;

  logic        w_cargar;
  logic        w_paso;
  logic        w_final;
  logic [3:0]  w_digito;
  logic        w_digito_inv;
  logic        w_err_total;
  logic [15:0] w_mac;

  assign w_digito     = r_digitos[r_idx];
  assign w_digito_inv = (w_digito > pkg_bcd::MAX_DIGITO);
  assign w_err_total  = r_err_acum | w_digito_inv;

  module_mac10 u_mac10 (
    .i_acc       (r_acc),
    .i_digito    (w_digito),
    .o_resultado (w_mac)
  );

  // Next-state and control strobes; a start is only accepted outside ACUM.
  always_comb begin
    w_estado_sig = r_estado;
    w_cargar     = 1'b0;
    w_paso       = 1'b0;
    w_final      = 1'b0;
    case (r_estado)
      pkg_bcd::IDLE, pkg_bcd::FIN: begin
        if (inicio) begin
          w_cargar     = 1'b1;
          w_estado_sig = pkg_bcd::ACUM;
        end
      end
      pkg_bcd::ACUM: begin
        w_paso = 1'b1;
        if (r_idx == ULTIMO) begin
          w_final      = 1'b1;
          w_estado_sig = pkg_bcd::FIN;
        end
      end
      default: w_estado_sig = pkg_bcd::IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado      <= pkg_bcd::IDLE;
      r_acc         <= '0;
      r_idx         <= '0;
      r_err_acum    <= 1'b0;
      numero_output <= '0;
      listo         <= 1'b0;
      error         <= 1'b0;
      for (int i = 0; i < int'(NUM_DIGITOS); i++) r_digitos[i] <= '0;
    end else begin
      r_estado <= w_estado_sig;
      if (w_cargar) begin
        r_digitos[0] <= millares_input;
        r_digitos[1] <= centenas_input;
        r_digitos[2] <= decenas_input;
        r_digitos[3] <= unidades_input;
        r_acc        <= '0;
        r_idx        <= '0;
        r_err_acum   <= 1'b0;
        listo        <= 1'b0;
        error        <= 1'b0;
      end else if (w_paso) begin
        r_acc      <= w_mac;
        r_idx      <= IDX_W'(r_idx + IDX_W'(1));
        r_err_acum <= w_err_total;
        if (w_final) begin
          listo         <= 1'b1;
          error         <= w_err_total;
          numero_output <= w_err_total ? 16'd0 : w_mac;
        end
      end
    end
  end

endmodule

// File: tb/tb_module_bcd_binario.sv
// Self-checking bench for module_bcd_binario with directed and random conversions.
module tb_module_bcd_binario;

  logic        clk;
  logic        rst;
  logic        inicio;
  logic [3:0]  millares_input;
  logic [3:0]  centenas_input;
  logic [3:0]  decenas_input;
  logic [3:0]  unidades_input;
  logic [15:0] numero_output;
  logic        listo;
  logic        error;

  int n_checks;
  int n_errors;

  module_bcd_binario #(.NUM_DIGITOS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .inicio         (inicio),
    .millares_input (millares_input),
    .centenas_input (centenas_input),
    .decenas_input  (decenas_input),
    .unidades_input (unidades_input),
    .numero_output  (numero_output),
    .listo          (listo),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Reference: decimal value of the four digits, or zero/error if any digit > 9.
  function automatic logic [15:0] modelo_valor(input int m, input int c, input int d, input int u);
    if (m > 9 || c > 9 || d > 9 || u > 9) return 16'd0;
    return 16'(m * 1000 + c * 100 + d * 10 + u);
  endfunction

  function automatic logic modelo_error(input int m, input int c, input int d, input int u);
    return (m > 9 || c > 9 || d > 9 || u > 9);
  endfunction

  // Drives one start edge; returns at the negedge right after the sampling edge.
  task automatic iniciar(input logic [3:0] m, input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
    @(negedge clk);
    millares_input = m; centenas_input = c; decenas_input = d; unidades_input = u;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    millares_input = $urandom_range(0, 15); centenas_input = $urandom_range(0, 15);
    decenas_input  = $urandom_range(0, 15); unidades_input = $urandom_range(0, 15);
  endtask

  // Counts edges until listo rises (0 if it never does within the budget).
  task automatic esperar_listo(output int lat);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (listo) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; inicio = 1'b1;
    millares_input = 4'd1; centenas_input = 4'd2; decenas_input = 4'd3; unidades_input = 4'd4;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (numero_output !== 16'd0) begin n_errors++; $display("FAIL reset_num got=%0d exp=0", numero_output); end
    n_checks++; if (listo !== 1'b0) begin n_errors++; $display("FAIL reset_listo got=%b exp=0", listo); end
    n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL reset_error got=%b exp=0", error); end
    rst = 1'b0; inicio = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (listo !== 1'b0) begin n_errors++; $display("FAIL reset_priority_listo cyc=%0d got=%b exp=0", k, listo); end
    end
  endtask

  task automatic test_directos;
    int lat;
    iniciar(4'd1, 4'd2, 4'd3, 4'd4);
    n_checks++; if (listo !== 1'b0) begin n_errors++; $display("FAIL start_clears_listo got=%b exp=0", listo); end
    esperar_listo(lat);
    n_checks++; if (lat != 4) begin n_errors++; $display("FAIL lat_1234 got=%0d exp=4", lat); end
    n_checks++; if (numero_output !== 16'd1234) begin n_errors++; $display("FAIL num_1234 got=%0d exp=1234", numero_output); end
    n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL err_1234 got=%b exp=0", error); end
    repeat (3) @(negedge clk);
    n_checks++; if (listo !== 1'b1) begin n_errors++; $display("FAIL listo_level got=%b exp=1", listo); end

    iniciar(4'd9, 4'd9, 4'd9, 4'd9);
    esperar_listo(lat);
    n_checks++; if (lat != 4) begin n_errors++; $display("FAIL lat_9999 got=%0d exp=4", lat); end
    n_checks++; if (numero_output !== 16'h270F) begin n_errors++; $display("FAIL num_9999 got=%0d exp=9999", numero_output); end
    n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL err_9999 got=%b exp=0", error); end

    iniciar(4'd0, 4'd0, 4'd0, 4'd0);
    n_checks++; if (listo !== 1'b0) begin n_errors++; $display("FAIL listo_drop_0000 got=%b exp=0", listo); end
    esperar_listo(lat);
    n_checks++; if (lat != 4) begin n_errors++; $display("FAIL lat_0000 got=%0d exp=4", lat); end
    n_checks++; if (numero_output !== 16'd0) begin n_errors++; $display("FAIL num_0000 got=%0d exp=0", numero_output); end

    iniciar(4'd5, 4'hA, 4'd7, 4'd8);
    esperar_listo(lat);
    n_checks++; if (lat != 4) begin n_errors++; $display("FAIL lat_5A78 got=%0d exp=4", lat); end
    n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL err_5A78 got=%b exp=1", error); end
    n_checks++; if (numero_output !== 16'd0) begin n_errors++; $display("FAIL num_5A78 got=%0d exp=0", numero_output); end
  endtask

  task automatic test_ignorar_inicio;
    int lat;
    iniciar(4'd5, 4'd6, 4'd7, 4'd8);
    @(negedge clk);
    inicio = 1'b1;
    millares_input = 4'd1; centenas_input = 4'd1; decenas_input = 4'd1; unidades_input = 4'd1;
    @(negedge clk);
    inicio = 1'b0;
    lat = 0;
    for (int k = 3; k <= 12; k++) begin
      @(negedge clk);
      if (listo) begin lat = k; break; end
    end
    n_checks++; if (lat != 4) begin n_errors++; $display("FAIL lat_ignore got=%0d exp=4", lat); end
    n_checks++; if (numero_output !== 16'd5678) begin n_errors++; $display("FAIL num_ignore got=%0d exp=5678", numero_output); end
    n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL err_ignore got=%b exp=0", error); end
  endtask

  task automatic test_reset_abort;
    int lat;
    iniciar(4'd0, 4'd9, 4'd1, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (listo !== 1'b0) begin n_errors++; $display("FAIL abort_listo got=%b exp=0", listo); end
    n_checks++; if (numero_output !== 16'd0) begin n_errors++; $display("FAIL abort_num got=%0d exp=0", numero_output); end
    n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL abort_error got=%b exp=0", error); end
    repeat (4) @(negedge clk);
    n_checks++; if (listo !== 1'b0 || numero_output !== 16'd0) begin
      n_errors++; $display("FAIL abort_no_resume listo=%b num=%0d exp listo=0 num=0", listo, numero_output);
    end
    iniciar(4'd0, 4'd9, 4'd1, 4'd0);
    esperar_listo(lat);
    n_checks++; if (lat != 4) begin n_errors++; $display("FAIL lat_0910 got=%0d exp=4", lat); end
    n_checks++; if (numero_output !== 16'd910) begin n_errors++; $display("FAIL num_0910 got=%0d exp=910", numero_output); end
  endtask

  task automatic test_aleatorio;
    int m, c, d, u, lat;
    logic [15:0] anterior;
    logic [15:0] esperado;
    anterior = numero_output === 16'd910 ? 16'd910 : 16'd910;
    for (int t = 0; t < 25; t++) begin
      m = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      c = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      u = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      esperado = modelo_valor(m, c, d, u);
      iniciar(4'(m), 4'(c), 4'(d), 4'(u));
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
        if (k > 1) inicio = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        if (listo) begin lat = k; break; end
        n_checks++;
        if (numero_output !== anterior) begin
          n_errors++; $display("FAIL rnd_hold t=%0d got=%0d exp=%0d", t, numero_output, anterior);
        end
      end
      inicio = 1'b0;
      n_checks++; if (lat != 4) begin n_errors++; $display("FAIL rnd_lat t=%0d got=%0d exp=4", t, lat); end
      n_checks++; if (numero_output !== esperado) begin
        n_errors++; $display("FAIL rnd_num t=%0d digits=%0d,%0d,%0d,%0d got=%0d exp=%0d", t, m, c, d, u, numero_output, esperado);
      end
      n_checks++; if (error !== modelo_error(m, c, d, u)) begin
        n_errors++; $display("FAIL rnd_err t=%0d got=%b exp=%b", t, error, modelo_error(m, c, d, u));
      end
      n_checks++; if (numero_output[15:14] !== 2'b00) begin
        n_errors++; $display("FAIL rnd_msb t=%0d got=%b exp=00", t, numero_output[15:14]);
      end
      anterior = esperado;
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int altos [$];
    iniciar(4'd1, 4'd2, 4'd3, 4'd4);
    esperar_listo(lat);
    n_checks++; if (numero_output !== 16'd1234) begin n_errors++; $display("FAIL b2b_first got=%0d exp=1234", numero_output); end
    inicio = 1'b1;
    millares_input = 4'd1; centenas_input = 4'd2; decenas_input = 4'd3; unidades_input = 4'd4;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (listo) altos.push_back(k);
      n_checks++;
      if (numero_output !== 16'd1234 || error !== 1'b0) begin
        n_errors++; $display("FAIL b2b_value cyc=%0d got=%0d err=%b exp=1234 err=0", k, numero_output, error);
      end
    end
    inicio = 1'b0;
    n_checks++; if (altos.size() != 4) begin n_errors++; $display("FAIL b2b_pulses got=%0d exp=4", altos.size()); end
    for (int i = 0; i < altos.size(); i++) begin
      n_checks++;
      if (altos[i] != 5 * (i + 1)) begin
        n_errors++; $display("FAIL b2b_period idx=%0d got=%0d exp=%0d", i, altos[i], 5 * (i + 1));
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; inicio = 1'b0;
    millares_input = '0; centenas_input = '0; decenas_input = '0; unidades_input = '0;
    n_checks = 0; n_errors = 0;
    test_reset();
    test_directos();
    test_ignorar_inicio();
    test_reset_abort();
    test_aleatorio();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/module_bcd_binario.md
MODULE_BCD_BINARIO -- requirements
Module: module_bcd_binario

Interface
REQ-001 The block SHALL use one clock `clk` and a synchronous, active-high reset `rst`; all state SHALL update only on the rising edge of `clk`.
REQ-002 The ports SHALL be, in order:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- inicio  input  1  start request, sampled on the rising edge
- millares_input  input  4  BCD thousands digit
- centenas_input  input  4  BCD hundreds digit
- decenas_input  input  4  BCD tens digit
- unidades_input  input  4  BCD units digit
- numero_output  output  16  binary value of the 4-digit BCD number
- listo  output  1  conversion complete, result valid
- error  output  1  last conversion had an invalid digit (>9)
REQ-003 The block SHALL have one parameter: NUM_DIGITOS, default 4, meaning the number of BCD digits converted.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACUM and FIN.
REQ-005 Start: in IDLE or FIN, when `inicio`=1 at an edge:
- all four digits latched
- accumulator cleared to 0
- digit index set to 0 (millares)
- `listo` and `error` cleared
- next state ACUM
REQ-006 Accumulate: in ACUM, each edge SHALL compute acc <= acc*10 + digit[index], processing millares, centenas, decenas, unidades in that order; index increments by 1.
REQ-007 The multiply by 10 SHALL be done as (acc<<3)+(acc<<1), with no `*` operator; all intermediate values SHALL be 16 bits wide.
REQ-008 On the 4th ACUM edge the block SHALL:
- load `numero_output` with the final value
- set `listo`=1
- enter FIN
REQ-009 Latency SHALL be 4 clocks: `listo` rises at the 4th edge after the edge that sampled `inicio`.
REQ-010 `listo` SHALL be a level: it stays 1 in FIN until the next accepted `inicio` or `rst`.
REQ-011 `numero_output` SHALL hold its last value except when updated at completion or by reset; during ACUM it SHALL keep the previous result.
REQ-012 Invalid digit: if any latched digit >9, completion SHALL still occur at the same latency, with `error`=1, `numero_output`=16'd0 and `listo`=1.
REQ-013 `inicio` asserted during ACUM SHALL be ignored, with no restart and no change of latched digits; digit inputs SHALL be don't-care outside the start edge.
REQ-014 `inicio` held high in FIN SHALL start a new conversion at every FIN edge.
REQ-015 The maximum valid result is 9999 (16'h270F); bits [15:14] of `numero_output` SHALL always be 0.

Reset
REQ-016 When `rst`=1 at an edge, the block SHALL go to IDLE with:
- numero_output=0, listo=0, error=0
- accumulator=0, index=0
- latched digits cleared
REQ-017 Reset SHALL take priority over `inicio`, including `rst` and `inicio` high at the same edge.
REQ-018 Reset during ACUM SHALL abort the conversion, with no partial result on `numero_output`.

Structure
REQ-019 A shared package `pkg_bcd` SHALL hold:
- state enum `estado_t` (IDLE, ACUM, FIN)
- constants NUM_DIGITOS=4, BASE=10, MAX_DIGITO=4'd9
REQ-020 The combinational step acc*10+digit SHALL be a sub-module `module_mac10` (16-bit acc in, 4-bit digit in, 16-bit out), instantiated once.
REQ-021 The digits SHALL be stored as a 4-entry array of 4-bit values, indexed by a 2-bit counter.

Verification
REQ-022 The bench SHALL cover:
- Digits 1,2,3,4, inicio one cycle -> listo high 4 clocks later, numero_output=16'd1234, error=0.
- Digits 9,9,9,9 -> numero_output=16'd9999 (16'h270F), error=0; then digits 0,0,0,0 -> 16'd0, listo re-asserted.
- Digits 5,A,7,8 -> after 4 clocks listo=1, error=1, numero_output=0.
- Start 5,6,7,8; pulse inicio with digits 1,1,1,1 in the 2nd ACUM cycle -> result 16'd5678 at the original latency.
- Start 0,9,1,0; assert rst in the 2nd ACUM cycle -> next edge listo=0, numero_output=0, error=0; a fresh start of 0,9,1,0 yields 16'd910.
- inicio held high with 1,2,3,4 -> listo pulses 1 cycle every 5 clocks, numero_output constant 16'd1234.
